// File: rtl/register_file.sv
// register_file: DEPTH x DATA_WIDTH general-purpose register storage with one
// synchronous write port and two independent, enable-gated combinational read
// ports. Sits between instruction decode (operand fetch) and execute
// (result write-back).
//
// Reset is synchronous and active-low and takes priority over a write on the
// same edge. Reads are purely combinational, so a write becomes visible only
// after its capturing edge; there is no bypass before that edge. A disabled
// read port drives all zeros.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    output logic [DATA_WIDTH-1:0] rdDataA,
    output logic [DATA_WIDTH-1:0] rdDataB,
    input  logic                  clk,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic                  REA,
    input  logic                  REB,
    input  logic [ADDR_WIDTH-1:0] rdAddrA,
    input  logic [ADDR_WIDTH-1:0] rdAddrB,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rst_n
);

    // Register array. Every entry, including index 0, is ordinary writable
    // storage with no hardwired value.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_a_s;
    logic [DATA_WIDTH-1:0] rd_data_b_s;

    // Storage update: reset clears every entry and discards a concurrent write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (write) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Read port A: follows address and enable changes combinationally.
    always_comb begin
        rd_data_a_s = {DATA_WIDTH{1'b0}};
        if (REA) begin
            rd_data_a_s = mem_r[rdAddrA];
        end else begin
            rd_data_a_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Read port B: independent of port A; both ports may read the same entry.
    always_comb begin
        rd_data_b_s = {DATA_WIDTH{1'b0}};
        if (REB) begin
            rd_data_b_s = mem_r[rdAddrB];
        end else begin
            rd_data_b_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign rdDataA = rd_data_a_s;
    assign rdDataB = rd_data_b_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. A behavioural array model is checked
// against both read ports on every falling edge. Directed vectors add
// hand-computed literal expectations that also pin the model.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic          write;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          REA;
    logic          REB;
    logic [AW-1:0] rdAddrA;
    logic [AW-1:0] rdAddrB;
    logic [DW-1:0] rdDataA;
    logic [DW-1:0] rdDataB;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one integer array indexed by address.
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_valid = 1'b0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .rdDataA (rdDataA),
        .rdDataB (rdDataB),
        .clk     (clk),
        .write   (write),
        .wrAddr  (wrAddr),
        .REA     (REA),
        .REB     (REB),
        .rdAddrA (rdAddrA),
        .rdAddrB (rdAddrB),
        .wrData  (wrData),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the rising edge: reset wins, otherwise an enabled write lands.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_valid = 1'b1;
        end else if (write) begin
            model_mem[wrAddr] = wrData;
        end
    end

    // Compare both read ports against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_port_a", rdDataA, REA ? model_mem[rdAddrA] : 32'd0);
            check("cmp_port_b", rdDataB, REB ? model_mem[rdAddrB] : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic [AW-1:0] addr_b;

        rst_n = 1'b0; write = 1'b0; wrAddr = '0; wrData = '0;
        REA = 1'b0; REB = 1'b0; rdAddrA = '0; rdAddrB = '0;
        step();
        rst_n = 1'b1;
        REA = 1'b1; REB = 1'b1; rdAddrA = 5'd0; rdAddrB = 5'd31;
        #1;
        check("reset_a0", rdDataA, 32'd0);
        check("reset_b31", rdDataB, 32'd0);

        // Reset clear: preload, then a reset edge with a concurrent write.
        write = 1'b1; wrAddr = 5'd7; wrData = 32'hDEADBEEF;
        step();
        write = 1'b0; rdAddrA = 5'd7;
        #1;
        check("preload_7", rdDataA, 32'hDEADBEEF);
        rst_n = 1'b0; write = 1'b1; wrAddr = 5'd7; wrData = 32'd5;
        step();
        rst_n = 1'b1; write = 1'b0;
        #1;
        check("reset_clear_7", rdDataA, 32'd0);

        // Fill: mem[i] = 11111*(i+1).
        for (int i = 0; i < DEPTH; i++) begin
            write = 1'b1; wrAddr = AW'(i); wrData = DW'(11111 * (i + 1));
            step();
        end
        write = 1'b0;

        // Sweep with enable gating on selected indices.
        for (int k = 0; k < DEPTH; k++) begin
            addr_b = AW'(k) - 5'd1;
            rdAddrA = AW'(k); rdAddrB = addr_b;
            REA = !(k == 2 || k == 5);
            REB = !(k == 0 || k == 9);
            #1;
            exp_a = REA ? DW'(11111 * (k + 1)) : 32'd0;
            exp_b = REB ? ((k == 0) ? 32'd355552 : DW'(11111 * k)) : 32'd0;
            check("sweep_a", rdDataA, exp_a);
            check("sweep_b", rdDataB, exp_b);
            if (k == 2) check("gate_k2_b", rdDataB, 32'd22222);
            step();
        end

        // Wrapped address 0-1 arrives as 31.
        REA = 1'b1; REB = 1'b1; rdAddrA = 5'd0; addr_b = 5'd0 - 5'd1; rdAddrB = addr_b;
        #1;
        check("wrap_b31", rdDataB, 32'd355552);
        check("wrap_a0", rdDataA, 32'd11111);

        // Write disable.
        write = 1'b0; wrAddr = 5'd3; wrData = 32'd1;
        repeat (4) step();
        rdAddrA = 5'd3;
        #1;
        check("write_disable_3", rdDataA, 32'd44444);

        // Write timing: old value before the edge, new value after.
        write = 1'b1; wrAddr = 5'd4; wrData = 32'h12345678; rdAddrA = 5'd4;
        #1;
        check("pre_edge_4", rdDataA, 32'd55555);
        step();
        write = 1'b0;
        check("post_edge_4", rdDataA, 32'h12345678);

        // Dual same-address read.
        rdAddrA = 5'd31; rdAddrB = 5'd31;
        #1;
        check("dual_a31", rdDataA, 32'd355552);
        check("dual_b31", rdDataB, 32'd355552);

        // A reset pulse between edges has no effect.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        step();
        check("no_async_reset", rdDataA, 32'd355552);

        // Reset mid-operation discards the concurrent write.
        rst_n = 1'b0; write = 1'b1; wrAddr = 5'd10; wrData = 32'hCAFEF00D;
        step();
        rst_n = 1'b1; write = 1'b0; rdAddrA = 5'd10; rdAddrB = 5'd20;
        #1;
        check("mid_reset_a10", rdDataA, 32'd0);
        check("mid_reset_b20", rdDataB, 32'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Multi-ported general-purpose register storage: DEPTH words of DATA_WIDTH bits with one synchronous write port and two independent, enable-gated combinational read ports (A and B). It sits in the datapath between instruction decode and the execute stage. It supplies two source operands per cycle and accepts one result write-back per cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, width of all address ports
- DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  sole clock; all state changes on rising edge
- rst_n  input  1  reset; synchronous, active-low
- rdDataA  output  DATA_WIDTH  read data, port A
- rdDataB  output  DATA_WIDTH  read data, port B
- write  input  1  write enable, active-high
- wrAddr  input  ADDR_WIDTH  write address
- REA  input  1  read enable, port A, active-high
- REB  input  1  read enable, port B, active-high
- rdAddrA  input  ADDR_WIDTH  read address, port A
- rdAddrB  input  ADDR_WIDTH  read address, port B
- wrData  input  DATA_WIDTH  write data

Port order for positional instantiation: rdDataA, rdDataB, clk, write, wrAddr, REA, REB, rdAddrA, rdAddrB, wrData, rst_n.

## Operation
- Storage: DEPTH registers, index 0..DEPTH-1. All registers, including index 0, are ordinary writable storage with no hardwired value.
- Reset: on a rising clk edge with rst_n=0, every register is cleared to 0. Reset has priority over write.
- Write: on a rising clk edge with rst_n=1 and write=1, mem[wrAddr] <= wrData. With write=0, no register changes.
- Read A: rdDataA = REA ? mem[rdAddrA] : 0. This path is purely combinational and tracks address and enable changes without waiting for a clock edge.
- Read B: same rule, using REB, rdAddrB and rdDataB. Ports A and B are fully independent and may read the same address.
- Addresses are unsigned ADDR_WIDTH-bit values. Upstream arithmetic wraps modulo DEPTH. For example, address 0-1 arrives as DEPTH-1 (31).
- No X propagation from disabled ports: a disabled port drives all zeros, never Z.

## Timing
- Write latency: 1 edge. Data is visible on a read port immediately after the capturing rising edge, within the same cycle after combinational settling.
- There is no write-to-read bypass before the edge. A read of wrAddr while write=1 returns the old contents until the edge, then the new contents.
- Read latency: 0 cycles (combinational) from rdAddr*/RE* to rdData*.
- Reset mid-operation: when rst_n is sampled low, the write on that edge is discarded. After that edge, all enabled reads return 0.
- Reset has no effect between edges. Registers hold their contents until an edge samples rst_n=0.
- Output reset values: after a reset edge, rdDataA and rdDataB are 0 for any address or enable setting.
- Simultaneous events: a write and two reads in the same cycle are all legal. Writes to the same address on consecutive edges simply overwrite.

## Test plan
- Reset clear: preload mem[7]=32'hDEADBEEF, then hold rst_n=0 for one edge with write=1, wrAddr=7, wrData=5. Required: REA=1, rdAddrA=7 gives rdDataA=0.
- Fill and readback: for i=0..31, write wrData=11111*(i+1) to wrAddr=i, one per edge. Then set REA=REB=1 and sweep k=0..31 with rdAddrA=k, rdAddrB=k-1. Required: rdDataA=11111*(k+1) and rdDataB=11111*k; for k=0, rdAddrB=31 gives 355552.
- Enable gating: during the sweep, drop REA at k=2 and k=5, and drop REB at k=0 and k=9. Required: the gated port reads 0, and the other port is unaffected (e.g. k=2 gives rdDataB=22222).
- Write disable: with write=0, drive wrAddr=3 and wrData=1 for several edges. Required: mem[3] still reads 44444.
- Write timing: with write=1, wrAddr=4, wrData=32'h12345678 and rdAddrA=4, REA=1, rdDataA holds the old value 55555 before the edge. Required: it reads 32'h12345678 after the edge.
- Dual same-address read: set rdAddrA=rdAddrB=31 with both enables high. Required: both ports read 355552.
